// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between a queued pixel writer and W-pixel line fetches; reads win, a burst never breaks.
// Line data follows its address by one cycle; wr_ready is deasserted while the write FIFO is full.
module spram_arbiter #(
  parameter int W          = 50,
  parameter int H          = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  input  logic [11:0] wr_data,
  output logic        wr_ready,
  input  logic        frame_clear,
  output logic        frame_done,
  input  logic        line_req,
  input  logic [7:0]  line_row,
  output logic        line_valid,
  output logic [11:0] line_data,
  output logic [7:0]  line_idx,
  output logic        line_done,
  output logic [1:0]  err_flags,
  output logic [14:0] spram_addr,
  output logic [11:0] spram_wr_data,
  output logic        spram_wre,
  output logic        spram_ce,
  input  logic [11:0] spram_rd_data
);

  localparam int            AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [14:0]   LAST_ADDR = 15'(W * H - 1);
  localparam logic [7:0]    LAST_K    = 8'(W - 1);
  localparam logic [14:0]   W15       = 15'(W);
  localparam logic [8:0]    H9        = 9'(H);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q;
  logic [11:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] fifo_wp_q, fifo_rp_q;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [14:0]   wr_ptr_q, wr_ptr_d;
  logic          pend_q;
  logic [7:0]    pend_row_q;
  logic [7:0]    rd_k_q;
  logic          wr_ready_q, frame_done_q, line_valid_q, line_done_q;
  logic [7:0]    line_idx_q;
  logic [1:0]    err_q;
  logic [14:0]   spram_addr_q;
  logic [11:0]   spram_wr_data_q;
  logic          spram_wre_q, spram_ce_q;

  logic push, issue_wr, start_rd, rd_last, row_ok;

  always_comb begin
    row_ok   = {1'b0, line_row} < H9;
    push     = wr_valid && wr_ready_q && !frame_clear;
    start_rd = (state_q == IDLE) && pend_q;
    // a pending fetch blocks new writes so the FSM drains to IDLE and then reads
    issue_wr = (state_q != READ) && !pend_q && (fifo_cnt_q != '0) && !frame_clear;
    rd_last  = (state_q == READ) && (rd_k_q == LAST_K);

    fifo_cnt_d = fifo_cnt_q;
    if (frame_clear)          fifo_cnt_d = '0;
    else if (push && !issue_wr) fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!push && issue_wr) fifo_cnt_d = fifo_cnt_q - CW'(1);

    wr_ptr_d = wr_ptr_q;
    if (frame_clear)   wr_ptr_d = '0;
    else if (issue_wr) wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 15'd1;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      fifo_wp_q       <= '0;
      fifo_rp_q       <= '0;
      fifo_cnt_q      <= '0;
      wr_ptr_q        <= '0;
      pend_q          <= 1'b0;
      pend_row_q      <= '0;
      rd_k_q          <= '0;
      wr_ready_q      <= 1'b0;
      frame_done_q    <= 1'b0;
      line_valid_q    <= 1'b0;
      line_done_q     <= 1'b0;
      line_idx_q      <= '0;
      err_q           <= '0;
      spram_addr_q    <= '0;
      spram_wr_data_q <= '0;
      spram_wre_q     <= 1'b0;
      spram_ce_q      <= 1'b1;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      wr_ready_q <= (fifo_cnt_d != FULL_CNT);
      wr_ptr_q   <= wr_ptr_d;
      if (frame_clear) begin
        fifo_wp_q <= '0;
        fifo_rp_q <= '0;
      end else begin
        if (push)     fifo_wp_q <= fifo_wp_q + AW'(1);
        if (issue_wr) fifo_rp_q <= fifo_rp_q + AW'(1);
      end

      frame_done_q <= issue_wr && (wr_ptr_q == LAST_ADDR);
      line_valid_q <= (state_q == READ);
      line_done_q  <= rd_last;
      if (state_q == READ) line_idx_q <= rd_k_q;

      // a request landing while the old one is consumed simply replaces it
      if (start_rd) pend_q <= 1'b0;
      if (line_req) begin
        if (!row_ok) begin
          err_q[1] <= 1'b1;
        end else begin
          pend_q     <= 1'b1;
          pend_row_q <= line_row;
          if (pend_q && !start_rd) err_q[0] <= 1'b1;
        end
      end

      spram_ce_q      <= 1'b1;
      spram_wre_q     <= issue_wr;
      spram_wr_data_q <= issue_wr ? fifo_mem[fifo_rp_q] : 12'h000;

      case (state_q)
        IDLE: begin
          if (start_rd) begin
            state_q      <= READ;
            spram_addr_q <= {7'b0, pend_row_q} * W15;
            rd_k_q       <= '0;
          end else if (issue_wr) begin
            state_q      <= WRITE;
            spram_addr_q <= wr_ptr_q;
          end
        end
        WRITE: begin
          if (issue_wr) spram_addr_q <= wr_ptr_q;
          else          state_q      <= IDLE;
        end
        READ: begin
          if (rd_last) begin
            state_q <= IDLE;
          end else begin
            rd_k_q       <= rd_k_q + 8'd1;
            spram_addr_q <= spram_addr_q + 15'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ready      = wr_ready_q;
  assign frame_done    = frame_done_q;
  assign line_valid    = line_valid_q;
  assign line_data     = line_valid_q ? spram_rd_data : 12'h000;
  assign line_idx      = line_idx_q;
  assign line_done     = line_done_q;
  assign err_flags     = err_q;
  assign spram_addr    = spram_addr_q;
  assign spram_wr_data = spram_wr_data_q;
  assign spram_wre     = spram_wre_q;
  assign spram_ce      = spram_ce_q;

endmodule
